fattree_adaptive_route_unit: RTL and testbench
==============================================

Name: fattree_adaptive_route_unit

Overview:
Registered, parametrised fat-tree route-computation stage for one router input port. It evaluates the nearest-common-ancestor (NCA) down/up decision on each incoming head flit's destination address. When the flit must go up, it selects one of K up-ports using one of three modes: straight (d-mod-k), pseudo-random (LFSR) or credit-adaptive. The result is emitted through a one-deep valid/ready pipeline register that sits between the input buffer and the VC/switch allocator.

Parameters:
K, 2, down-ports and up-ports per router (K >= 2).
L, 3, fat-tree levels; level 0 = leaf routers, level L-1 = root routers.
UP_MODE, "ADAPTIVE", one of "STRAIGHT", "RANDOM", "ADAPTIVE".
CRDw, 4, width of each up-port free-credit count.
LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Derived constants:
Kw=log2(K), Lw=log2(L), LKw=L*Kw, DSPw=log2(2K).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
current_addr_encoded  in  LKw  this router's address digits (quasi-static)
current_level  in  Lw  this router's level (quasi-static)
in_valid  in  1  head flit destination presented
in_ready  out  1  stage can accept
in_dest_addr_encoded  in  LKw  destination endpoint digits; digit j = bits [(j+1)Kw-1 : jKw]
up_credit  in  K*CRDw  free credits of up-ports K..2K-1; field i belongs to port K+i
out_valid  out  1  routed result held
out_ready  in  1  downstream consumes result
out_destport_encoded  out  DSPw  0..K-1 = down, K..2K-1 = up
out_went_up  out  1  result is an up route
up_route_cnt  out  16  saturating count of up routes issued

Behaviour:
- Reset is synchronous, active-high, one clock. On reset: out_valid=0, out_destport_encoded=0, out_went_up=0, up_route_cnt=0, rr_ptr=0, lfsr=LFSR_SEED.
- Up decision: go up iff there exists j in [current_level+1, L-1] with current digit(j-1) != dest digit(j). A root router (current_level=L-1) never goes up.
- Down port = dest digit(current_level), zero-extended to DSPw.
- Up port selection:
  - STRAIGHT: K + dest digit(current_level).
  - RANDOM: K + (lfsr[Kw-1:0] mod K).
  - ADAPTIVE: among the K up credits, pick the maximum. Ties are broken by the first index at or after rr_ptr (cyclic). If all credits are 0, pick rr_ptr.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - An accept occurs when in_valid && in_ready; the result is registered on that edge, so latency is 1 cycle.
  - Outputs hold stable while out_valid && !out_ready.
  - Simultaneous consume and accept is allowed: back-to-back throughput is 1 per cycle.
  - With no accept and out_ready=1, out_valid clears.
- State updates happen on accept of an up route only:
  - LFSR: x^16+x^14+x^13+x^11+1, Fibonacci, advanced one step.
  - rr_ptr = (selected up-port index + 1) mod K, with wrap-around.
  - up_route_cnt increments and saturates at 16'hFFFF.
  - Down routes leave the LFSR, rr_ptr and counter unchanged.
- up_credit is sampled in the accept cycle only; credit changes while a result is stalled do not alter it.
- A reset asserted mid-stall drops the held result; the upstream must re-present it.
- K not a power of two: mod K on the LFSR bits uses a compare-subtract. Dest digits >= K are illegal; an assertion fires when not in synthesis.

Decomposition:
- Shared package/header entries: UP_MODE string constants, the log2 function, and Kw/Lw/DSPw derivations, reused by fat-tree router files.
- One natural sub-module: fattree_up_port_arbiter, holding the credit max-compare, round-robin tie-break, LFSR and rr_ptr.
- The NCA compare stays inline.

Test Plan:
1. K=2, L=3, leaf (level 0), current digits {d2=x, d1=1, d0=0}, dest {d2=0, d1=1, d0=1} -> up, since digit0 0 != dest digit1 1; out_went_up=1 and out_destport in {2,3}, 1 cycle after accept.
2. Same router, dest {d2=1, d1=0, d0=1} -> down, out_destport=1, out_went_up=0, up_route_cnt unchanged.
3. ADAPTIVE, credits {port2=3, port3=7} -> port 3. Then credits {5,5} with rr_ptr=0 -> port 2 and rr_ptr becomes 1. Then {5,5} again -> port 3.
4. out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, credit changes ignored. Then out_ready=1 with in_valid=1 -> consume and accept in the same cycle.
5. RANDOM mode: 4 up accepts after reset -> ports equal K + low Kw bits of the LFSR sequence from seed 16'hACE1, checked against the reference model. A root router with any dest -> down only.
6. Drive 65540 up routes -> up_route_cnt=16'hFFFF. Assert reset while out_valid=1 -> next cycle out_valid=0, rr_ptr=0, counter=0.

Source files
------------

// File: rtl/fattree_adaptive_route_unit_pkg.sv
// ============================================================================
// Module  : fattree_adaptive_route_unit_pkg
// Brief   : Shared fat-tree routing constants, up-port mode encoding, log2.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fattree_adaptive_route_unit_pkg;

   localparam string UP_MODE_STRAIGHT = "STRAIGHT";
   localparam string UP_MODE_RANDOM   = "RANDOM";
   localparam string UP_MODE_ADAPTIVE = "ADAPTIVE";

   typedef enum logic [1:0] {
      UPM_STRAIGHT = 2'd0,
      UPM_RANDOM   = 2'd1,
      UPM_ADAPTIVE = 2'd2
   } up_mode_e;

   localparam int LFSR_W = 16;

   // Ceiling log2, never below 1 so single-value fields still get a bit.
   function automatic int log2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int digit_width(input int k);
      return log2(k);
   endfunction

   function automatic int level_width(input int l);
      return log2(l);
   endfunction

   function automatic int destport_width(input int k);
      return log2(2 * k);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fattree_up_port_arbiter.sv
// ============================================================================
// Module  : fattree_up_port_arbiter
// Brief   : Up-port selector (straight / LFSR / credit-adaptive with RR ties).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fattree_up_port_arbiter
   import fattree_adaptive_route_unit_pkg::*;
#(
   parameter int          K         = 2,
   parameter int          CRDw      = 4,
   parameter up_mode_e    MODE      = UPM_ADAPTIVE,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [K*CRDw-1:0]          up_credit_i,
   input  logic [digit_width(K)-1:0]  straight_idx_i,
   input  logic                       advance_i,
   output logic [digit_width(K)-1:0]  sel_idx_o
);

   localparam int Kw = digit_width(K);

   logic [Kw-1:0]     rr_ptr_q, rr_ptr_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [CRDw-1:0]   w_cred [K];
   logic [Kw-1:0]     w_rand_idx;
   logic [Kw-1:0]     w_best_idx;
   logic [CRDw-1:0]   w_best_cred;

   for (genvar i = 0; i < K; i++) begin : g_cred_unpack
      assign w_cred[i] = up_credit_i[i*CRDw +: CRDw];
   end

   // Low LFSR bits span 0..2^Kw-1 < 2K, so one compare-subtract reduces mod K.
   always_comb begin
      int tmp;
      tmp = int'(lfsr_q[Kw-1:0]);
      if (tmp >= K) tmp = tmp - K;
      w_rand_idx = Kw'(tmp);
   end

   // Scan starting at rr_ptr; only a strictly larger credit displaces the
   // incumbent, so ties (including all-zero) resolve to the first from rr_ptr.
   always_comb begin
      w_best_idx  = rr_ptr_q;
      w_best_cred = w_cred[rr_ptr_q];
      for (int o = 1; o < K; o++) begin
         int idx;
         idx = int'(rr_ptr_q) + o;
         if (idx >= K) idx = idx - K;
         if (w_cred[idx] > w_best_cred) begin
            w_best_idx  = Kw'(idx);
            w_best_cred = w_cred[idx];
         end
      end
   end

   always_comb begin
      case (MODE)
         UPM_STRAIGHT: sel_idx_o = straight_idx_i;
         UPM_RANDOM:   sel_idx_o = w_rand_idx;
         default:      sel_idx_o = w_best_idx;
      endcase
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      lfsr_d   = lfsr_q;
      if (advance_i) begin
         rr_ptr_d = (int'(sel_idx_o) == K - 1) ? '0 : sel_idx_o + Kw'(1);
         lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         lfsr_q   <= LFSR_SEED;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         lfsr_q   <= lfsr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fattree_adaptive_route_unit.sv
// ============================================================================
// Module  : fattree_adaptive_route_unit
// Brief   : Registered fat-tree NCA route stage with selectable up-port mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fattree_adaptive_route_unit
   import fattree_adaptive_route_unit_pkg::*;
#(
   parameter int          K         = 2,
   parameter int          L         = 3,
   parameter string       UP_MODE   = "ADAPTIVE",
   parameter int          CRDw      = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [L*digit_width(K)-1:0]       current_addr_encoded,
   input  logic [level_width(L)-1:0]         current_level,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [L*digit_width(K)-1:0]       in_dest_addr_encoded,
   input  logic [K*CRDw-1:0]                 up_credit,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [destport_width(K)-1:0]      out_destport_encoded,
   output logic                              out_went_up,
   output logic [15:0]                       up_route_cnt
);

   localparam int Kw   = digit_width(K);
   localparam int Lw   = level_width(L);
   localparam int LKw  = L * Kw;
   localparam int DSPw = destport_width(K);

   localparam up_mode_e MODE = (UP_MODE == UP_MODE_STRAIGHT) ? UPM_STRAIGHT :
                               (UP_MODE == UP_MODE_RANDOM)   ? UPM_RANDOM   :
                                                               UPM_ADAPTIVE;

   logic            out_valid_q, out_valid_d;
   logic [DSPw-1:0] destport_q, destport_d;
   logic            went_up_q, went_up_d;
   logic [15:0]     up_cnt_q, up_cnt_d;

   logic            w_accept;
   logic            w_go_up;
   logic [Kw-1:0]   w_down_digit;
   logic [Kw-1:0]   w_up_idx;
   logic [DSPw-1:0] w_port;
   logic [Kw-1:0]   w_unused_top_digit;

   // The topmost current-address digit never participates in the NCA compare.
   assign w_unused_top_digit = current_addr_encoded[LKw-1 -: Kw];

   assign in_ready = !out_valid_q || out_ready;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_go_up      = 1'b0;
      w_down_digit = '0;
      for (int j = 1; j < L; j++) begin
         if ((j > int'(current_level)) &&
             (current_addr_encoded[(j-1)*Kw +: Kw] != in_dest_addr_encoded[j*Kw +: Kw]))
            w_go_up = 1'b1;
      end
      for (int j = 0; j < L; j++) begin
         if (int'(current_level) == j) w_down_digit = in_dest_addr_encoded[j*Kw +: Kw];
      end
   end

   fattree_up_port_arbiter #(
      .K         (K),
      .CRDw      (CRDw),
      .MODE      (MODE),
      .LFSR_SEED (LFSR_SEED)
   ) u_up_arb (
      .clk            (clk),
      .reset          (reset),
      .up_credit_i    (up_credit),
      .straight_idx_i (w_down_digit),
      .advance_i      (w_accept && w_go_up),
      .sel_idx_o      (w_up_idx)
   );

   assign w_port = w_go_up ? DSPw'(K + int'(w_up_idx)) : DSPw'(w_down_digit);

   always_comb begin
      out_valid_d = out_valid_q;
      destport_d  = destport_q;
      went_up_d   = went_up_q;
      up_cnt_d    = up_cnt_q;
      if (w_accept) begin
         out_valid_d = 1'b1;
         destport_d  = w_port;
         went_up_d   = w_go_up;
         if (w_go_up && (up_cnt_q != 16'hFFFF)) up_cnt_d = up_cnt_q + 16'd1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         destport_q  <= '0;
         went_up_q   <= 1'b0;
         up_cnt_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         destport_q  <= destport_d;
         went_up_q   <= went_up_d;
         up_cnt_q    <= up_cnt_d;
      end
   end

   assign out_valid            = out_valid_q;
   assign out_destport_encoded = destport_q;
   assign out_went_up          = went_up_q;
   assign up_route_cnt         = up_cnt_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset && w_accept) begin
         for (int j = 0; j < L; j++) begin
            assert (int'(in_dest_addr_encoded[j*Kw +: Kw]) < K);
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fattree_adaptive_route_unit.sv
// ============================================================================
// Module  : tb_fattree_adaptive_route_unit
// Brief   : Scoreboard bench driving ADAPTIVE, RANDOM and STRAIGHT instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fattree_adaptive_route_unit;

   localparam int K    = 2;
   localparam int L    = 3;
   localparam int CRDw = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cur_addr;
   logic [1:0]  cur_lvl;
   logic        in_valid;
   logic [2:0]  dest;
   logic [7:0]  up_credit;
   logic        out_ready;

   logic        in_ready  [3];
   logic        out_valid [3];
   logic [1:0]  port      [3];
   logic        went_up   [3];
   logic [15:0] cnt       [3];

   always #5 clk = ~clk;

   fattree_adaptive_route_unit #(.K(K), .L(L), .UP_MODE("ADAPTIVE"), .CRDw(CRDw), .LFSR_SEED(16'hACE1)) u_adp (
      .clk(clk), .reset(reset), .current_addr_encoded(cur_addr), .current_level(cur_lvl),
      .in_valid(in_valid), .in_ready(in_ready[0]), .in_dest_addr_encoded(dest), .up_credit(up_credit),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_destport_encoded(port[0]),
      .out_went_up(went_up[0]), .up_route_cnt(cnt[0]));

   fattree_adaptive_route_unit #(.K(K), .L(L), .UP_MODE("RANDOM"), .CRDw(CRDw), .LFSR_SEED(16'hACE1)) u_rnd (
      .clk(clk), .reset(reset), .current_addr_encoded(cur_addr), .current_level(cur_lvl),
      .in_valid(in_valid), .in_ready(in_ready[1]), .in_dest_addr_encoded(dest), .up_credit(up_credit),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_destport_encoded(port[1]),
      .out_went_up(went_up[1]), .up_route_cnt(cnt[1]));

   fattree_adaptive_route_unit #(.K(K), .L(L), .UP_MODE("STRAIGHT"), .CRDw(CRDw), .LFSR_SEED(16'hACE1)) u_str (
      .clk(clk), .reset(reset), .current_addr_encoded(cur_addr), .current_level(cur_lvl),
      .in_valid(in_valid), .in_ready(in_ready[2]), .in_dest_addr_encoded(dest), .up_credit(up_credit),
      .out_valid(out_valid[2]), .out_ready(out_ready), .out_destport_encoded(port[2]),
      .out_went_up(went_up[2]), .up_route_cnt(cnt[2]));

   typedef struct packed {
      logic [1:0]  pa;
      logic [1:0]  pr;
      logic [1:0]  ps;
      logic        up;
      logic [15:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          m_rr;
   logic [15:0] m_lfsr;
   logic [15:0] m_cnt;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rr   = 0;
      m_lfsr = 16'hACE1;
      m_cnt  = 16'h0000;
   endtask

   // Reference behaviour for K=2, L=3: digits are single bits.
   task automatic push_expected();
      exp_t       e;
      logic       up;
      logic [1:0] dn;
      logic [3:0] c0, c1;
      int         sel;
      up = 1'b0;
      for (int j = 1; j < L; j++)
         if (j > int'(cur_lvl) && cur_addr[j-1] != dest[j]) up = 1'b1;
      dn = {1'b0, dest[cur_lvl]};
      if (up) begin
         c0 = up_credit[3:0];
         c1 = up_credit[7:4];
         if (c0 == c1) sel = m_rr;
         else          sel = (c1 > c0) ? 1 : 0;
         e.pa   = 2'(2 + sel);
         e.pr   = 2'(2 + int'(m_lfsr[0]));
         e.ps   = 2'(2 + int'(dest[cur_lvl]));
         m_rr   = (sel == 1) ? 0 : 1;
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
         e.pa = dn;
         e.pr = dn;
         e.ps = dn;
      end
      e.up  = up;
      e.cnt = m_cnt;
      q.push_back(e);
   endtask

   // Monitor: pops one expectation per consumed result.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid[0] && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got port %0d expected no output", port[0]);
         end else begin
            e = q.pop_front();
            check("port_adaptive", 32'(port[0]), 32'(e.pa));
            check("port_random",   32'(port[1]), 32'(e.pr));
            check("port_straight", 32'(port[2]), 32'(e.ps));
            check("went_up_adp",   32'(went_up[0]), 32'(e.up));
            check("went_up_rnd",   32'(went_up[1]), 32'(e.up));
            check("valid_rnd",     32'(out_valid[1]), 32'd1);
            check("valid_str",     32'(out_valid[2]), 32'd1);
            check("up_route_cnt",  32'(cnt[0]), 32'(e.cnt));
         end
      end
   end

   task automatic send(input logic [2:0] d, input logic [7:0] cr);
      int n;
      in_valid  = 1'b1;
      dest      = d;
      up_credit = cr;
      n = 0;
      @(negedge clk);
      while (!in_ready[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[0]) begin
         check("accept_timeout", 32'(in_ready[0]), 32'd1);
      end else begin
         push_expected();
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      model_reset();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cur_addr  = 3'b010;
      cur_lvl   = 2'd0;
      dest      = 3'b000;
      up_credit = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      @(negedge clk);
      check("rst_out_valid", 32'(out_valid[0]), 32'd0);
      check("rst_destport",  32'(port[0]), 32'd0);
      check("rst_went_up",   32'(went_up[0]), 32'd0);
      check("rst_cnt",       32'(cnt[0]), 32'd0);
      check("rst_in_ready",  32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;

      // Leaf: up route, then a down route to port 1.
      send(3'b011, 8'h11);
      send(3'b101, 8'h11);
      drain();

      // Adaptive: {3,7} -> port 3; {5,5} rr=0 -> port 2; {5,5} rr=1 -> port 3.
      do_reset();
      send(3'b011, 8'h73);
      send(3'b011, 8'h55);
      send(3'b011, 8'h55);
      drain();

      // Stall with new flit pending: port stays 2 despite credits now favouring 3.
      out_ready = 1'b0;
      send(3'b011, 8'h19);
      in_valid  = 1'b1;
      dest      = 3'b101;
      up_credit = 8'hF1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready",  32'(in_ready[0]), 32'd0);
         check("stall_out_valid", 32'(out_valid[0]), 32'd1);
         check("stall_port",      32'(port[0]), 32'd2);
         check("stall_went_up",   32'(went_up[0]), 32'd1);
         @(posedge clk);
         #1;
         up_credit = ~up_credit;
      end
      out_ready = 1'b1;
      send(3'b011, 8'h1F);
      send(3'b101, 8'h00);
      drain();

      // LFSR-driven selection from seed, then root router routes only down.
      do_reset();
      send(3'b011, 8'h12);
      send(3'b001, 8'h34);
      send(3'b111, 8'h00);
      send(3'b011, 8'hA5);
      cur_lvl = 2'd2;
      send(3'b011, 8'h55);
      send(3'b100, 8'h55);
      send(3'b111, 8'h55);
      cur_lvl = 2'd0;
      drain();

      // Counter saturation over a long back-to-back burst.
      for (int i = 0; i < 65540; i++) send(3'b011, (i % 3 == 0) ? 8'h55 : 8'h2C);
      drain();
      check("cnt_saturated", 32'(cnt[0]), 32'h0000FFFF);

      // Reset while a result is held drops it and clears counter and rr_ptr.
      out_ready = 1'b0;
      send(3'b011, 8'h55);
      @(negedge clk);
      check("held_before_rst", 32'(out_valid[0]), 32'd1);
      @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid[0]), 32'd0);
      check("post_rst_cnt",   32'(cnt[0]), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(3'b011, 8'h55);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
